// File: rtl/dsp_arb_pkg.sv
// dsp_arb_pkg: shared widths, requester indices and pipeline record for the DSP add/sub arbiter
package dsp_arb_pkg;
  localparam int WIDTH = 32;
  localparam int NREQ_MAX = 4;
  localparam int REQ_ALU = 0;
  localparam int REQ_BRANCH = 1;
  typedef struct packed {
    logic                valid;
    logic [NREQ_MAX-1:0] id;
    logic                sub;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
  } pipe_rec_t;
endpackage

// File: rtl/dsp_addsub_unit.sv
// dsp_addsub_unit: combinational SB_MAC16-style 32-bit adder/subtractor, no input/output registers
module dsp_addsub_unit
  import dsp_arb_pkg::*;
(
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry_out
);
  logic [WIDTH:0] w_sum;
  // subtraction is A + ~B + 1, so the carry out means "no borrow" (A >= B unsigned)
  always_comb begin
    w_sum = {1'b0, i_a} + {1'b0, i_sub ? ~i_b : i_b} + {{WIDTH{1'b0}}, i_sub};
  end
  assign o_result = w_sum[WIDTH-1:0];
  assign o_carry_out = w_sum[WIDTH];
endmodule

// File: rtl/dsp_addsub_arbiter.sv
// dsp_addsub_arbiter: round-robin sharing of one DSP add/sub unit, 2-cycle latency, 1 op/cycle
module dsp_addsub_arbiter #(
  parameter int WIDTH = dsp_arb_pkg::WIDTH,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ-1:0]       i_req_sub,
  input  logic [NREQ*WIDTH-1:0] i_req_a,
  input  logic [NREQ*WIDTH-1:0] i_req_b,
  output logic [NREQ-1:0]       o_rsp_valid,
  output logic [WIDTH-1:0]      o_rsp_result,
  output logic                  o_rsp_carry,
  output logic                  o_rsp_zero
);
  import dsp_arb_pkg::*;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    w_gid;
  logic [PW-1:0]    w_cand;
  logic [NREQ-1:0]  w_gnt;
  logic             w_xfer;
  logic             w_id_ok;
  pipe_rec_t        r_s1;
  pipe_rec_t        w_s1;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic [NREQ-1:0]  r_rsp_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  // grant the first valid requester at or after the pointer; nothing while flushing or in reset
  always_comb begin
    w_gnt = '0;
    w_gid = '0;
    w_cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = PW'((int'(r_ptr) + k) % NREQ);
      if (i_req_valid[w_cand]) begin
        w_gnt = '0;
        w_gnt[w_cand] = 1'b1;
        w_gid = w_cand;
      end
    end
    if (i_flush || !rst_n) w_gnt = '0;
  end
  assign o_req_ready = w_gnt;
  assign w_xfer = |w_gnt;
  // next S1 record: operands of the winner on transfer, otherwise hold data and drop valid
  always_comb begin
    w_s1 = r_s1;
    w_s1.valid = w_xfer;
    if (w_xfer) begin
      w_s1.id = NREQ_MAX'(w_gnt);
      w_s1.sub = i_req_sub[w_gid];
      w_s1.a = i_req_a[int'(w_gid)*WIDTH +: WIDTH];
      w_s1.b = i_req_b[int'(w_gid)*WIDTH +: WIDTH];
    end
  end
  // advance the round-robin pointer past the requester that just transferred
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= '0;
    else if (w_xfer) r_ptr <= (32'(w_gid) == NREQ - 1) ? '0 : w_gid + PW'(1);
  end
  // S1 operand register; flush needs no term here since no grant is issued during flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_s1 <= '0;
    else r_s1 <= w_s1;
  end
  dsp_addsub_unit u_dsp (
    .i_a         (r_s1.a),
    .i_b         (r_s1.b),
    .i_sub       (r_s1.sub),
    .o_result    (w_result),
    .o_carry_out (w_carry)
  );
  assign w_id_ok = ~|(r_s1.id >> NREQ);
  // S2 result register; flush squashes the op currently sitting in S1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_result <= '0;
      r_carry <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      r_rsp_valid <= (r_s1.valid && w_id_ok && !i_flush) ? r_s1.id[NREQ-1:0] : '0;
      if (r_s1.valid) begin
        r_result <= w_result;
        r_carry <= w_carry;
        r_zero <= (w_result == '0);
      end
    end
  end
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_result = r_result;
  assign o_rsp_carry = r_carry;
  assign o_rsp_zero = r_zero;
endmodule

// File: tb/tb_dsp_addsub_arbiter.sv
// tb_dsp_addsub_arbiter: directed scenario tests for the shared DSP add/sub arbiter
module tb_dsp_addsub_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_sub = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_zero;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dsp_addsub_arbiter #(.WIDTH(32), .NREQ(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (flush),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_sub    (req_sub),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_result (rsp_result),
    .o_rsp_carry  (rsp_carry),
    .o_rsp_zero   (rsp_zero)
  );

  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_valid[p] = 1'b1;
    req_sub[p] = s;
    req_a[p*32 +: 32] = a;
    req_b[p*32 +: 32] = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    @(negedge clk); #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready: got %b want 00", req_ready); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
    total++; if (rsp_result !== 32'h0) begin bad++; $display("FAIL rst_result: got %h want 0", rsp_result); end
    total++; if (rsp_carry !== 1'b0) begin bad++; $display("FAIL rst_carry: got %b want 0", rsp_carry); end
    total++; if (rsp_zero !== 1'b0) begin bad++; $display("FAIL rst_zero: got %b want 0", rsp_zero); end
    @(negedge clk); rst_n = 1'b1; #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rst_first_grant: got %b want 01", req_ready); end
    @(negedge clk); #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rst_second_grant: got %b want 10", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL rst_rsp0: got %b want 01", rsp_valid); end
    total++; if (rsp_zero !== 1'b1) begin bad++; $display("FAIL rst_rsp0_zero: got %b want 1", rsp_zero); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL rst_rsp1: got %b want 10", rsp_valid); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_rsp_idle: got %b want 00", rsp_valid); end
  endtask

  task automatic test_single_sub();
    @(negedge clk); issue(1, 32'd5, 32'd7, 1'b1); #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL sub_ready: got %b want 10", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL sub_early: got %b want 00", rsp_valid); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL sub_valid: got %b want 10", rsp_valid); end
    total++; if (rsp_result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_result: got %h want fffffffe", rsp_result); end
    total++; if (rsp_carry !== 1'b0) begin bad++; $display("FAIL sub_carry: got %b want 0", rsp_carry); end
    total++; if (rsp_zero !== 1'b0) begin bad++; $display("FAIL sub_zero: got %b want 0", rsp_zero); end
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    @(negedge clk);
    issue(0, 32'd10, 32'd3, 1'b0);
    issue(1, 32'd100, 32'd1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k == 4) req_valid = 2'b00;
      #1;
      exp = (k % 2 != 0) ? 2'b10 : 2'b01;
      if (k < 4) begin
        total++; if (req_ready !== exp) begin bad++; $display("FAIL cont_ready[%0d]: got %b want %b", k, req_ready, exp); end
      end
      if (k < 2) begin
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL cont_rsp[%0d]: got %b want 00", k, rsp_valid); end
      end else begin
        total++; if (rsp_valid !== exp) begin bad++; $display("FAIL cont_rsp[%0d]: got %b want %b", k, rsp_valid, exp); end
        total++; if (rsp_result !== ((k % 2 != 0) ? 32'd99 : 32'd13)) begin bad++; $display("FAIL cont_result[%0d]: got %h want %h", k, rsp_result, (k % 2 != 0) ? 32'd99 : 32'd13); end
        total++; if (rsp_carry !== (k % 2 != 0)) begin bad++; $display("FAIL cont_carry[%0d]: got %b want %b", k, rsp_carry, (k % 2 != 0)); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_add_overflow();
    @(negedge clk); issue(0, 32'hFFFF_FFFF, 32'd1, 1'b0); #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL ovf_ready: got %b want 01", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL ovf_valid: got %b want 01", rsp_valid); end
    total++; if (rsp_result !== 32'h0) begin bad++; $display("FAIL ovf_result: got %h want 0", rsp_result); end
    total++; if (rsp_carry !== 1'b1) begin bad++; $display("FAIL ovf_carry: got %b want 1", rsp_carry); end
    total++; if (rsp_zero !== 1'b1) begin bad++; $display("FAIL ovf_zero: got %b want 1", rsp_zero); end
  endtask

  task automatic test_equal_sub();
    @(negedge clk); issue(1, 32'h8000_0000, 32'h8000_0000, 1'b1); #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL eq_ready: got %b want 10", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL eq_valid: got %b want 10", rsp_valid); end
    total++; if (rsp_result !== 32'h0) begin bad++; $display("FAIL eq_result: got %h want 0", rsp_result); end
    total++; if (rsp_carry !== 1'b1) begin bad++; $display("FAIL eq_carry: got %b want 1", rsp_carry); end
    total++; if (rsp_zero !== 1'b1) begin bad++; $display("FAIL eq_zero: got %b want 1", rsp_zero); end
  endtask

  task automatic test_flush();
    @(negedge clk); issue(0, 32'd1, 32'd2, 1'b0); #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL fl_ready0: got %b want 01", req_ready); end
    @(negedge clk); req_valid = 2'b00; issue(1, 32'd9, 32'd4, 1'b1); flush = 1'b1; #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL fl_no_grant: got %b want 00", req_ready); end
    @(negedge clk); flush = 1'b0; #1;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL fl_squash: got %b want 00", rsp_valid); end
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL fl_ready1: got %b want 10", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL fl_gap: got %b want 00", rsp_valid); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL fl_after: got %b want 10", rsp_valid); end
    total++; if (rsp_result !== 32'd5) begin bad++; $display("FAIL fl_result: got %h want 5", rsp_result); end
    total++; if (rsp_zero !== 1'b0) begin bad++; $display("FAIL fl_zero: got %b want 0", rsp_zero); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); issue(0, 32'd1, 32'd1, 1'b0); #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL ar_ready0: got %b want 01", req_ready); end
    @(negedge clk); req_valid = 2'b00; issue(1, 32'd20, 32'd5, 1'b1); #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL ar_ready1: got %b want 10", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL ar_rsp0: got %b want 01", rsp_valid); end
    total++; if (rsp_result !== 32'd2) begin bad++; $display("FAIL ar_result0: got %h want 2", rsp_result); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL ar_immediate: got %b want 00", rsp_valid); end
    total++; if (rsp_result !== 32'h0) begin bad++; $display("FAIL ar_result_clr: got %h want 0", rsp_result); end
    @(negedge clk); rst_n = 1'b1; #1;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL ar_stale: got %b want 00", rsp_valid); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL ar_stale2: got %b want 00", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); issue(0, 32'd7, 32'd8, 1'b0); #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL b2b_ready0: got %b want 01", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); issue(0, 32'd50, 32'd8, 1'b1); #1;
    total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL b2b_rsp0: got %b want 01", rsp_valid); end
    total++; if (rsp_result !== 32'd15) begin bad++; $display("FAIL b2b_result0: got %h want f", rsp_result); end
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL b2b_reissue: got %b want 01", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL b2b_gap: got %b want 00", rsp_valid); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL b2b_rsp1: got %b want 01", rsp_valid); end
    total++; if (rsp_result !== 32'd42) begin bad++; $display("FAIL b2b_result1: got %h want 2a", rsp_result); end
    total++; if (rsp_carry !== 1'b1) begin bad++; $display("FAIL b2b_carry1: got %b want 1", rsp_carry); end
  endtask

  initial begin
    test_reset();
    test_single_sub();
    test_contention();
    test_add_overflow();
    test_equal_sub();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
